// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the two-port ALU share arbiter: ALU op encoding, grant
// encoding, slot state and the ALU request/response structs.
package alu_share_arbiter_pkg;

  localparam int ALU_W = 32;

  // last_grant encoding
  localparam logic ARB_PORT0 = 1'b0;
  localparam logic ARB_PORT1 = 1'b1;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9
  } alu_op_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  typedef struct packed {
    logic [ALU_W-1:0] op1;
    logic [ALU_W-1:0] op2;
    logic [3:0]       op;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Core combinational ALU shared by both arbiter ports. Unknown op codes
// produce result 0 (and therefore zero = 1).
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
(
  input  alu_req_t i_req,
  output alu_rsp_t o_rsp
);

  logic [ALU_W-1:0] w_res;
  logic [4:0]       w_shamt;

  assign w_shamt = i_req.op2[4:0];

  always_comb begin
    w_res = '0;
    case (i_req.op)
      ALU_ADD:  w_res = i_req.op1 + i_req.op2;
      ALU_SUB:  w_res = i_req.op1 - i_req.op2;
      ALU_SLL:  w_res = i_req.op1 << w_shamt;
      ALU_SLT:  w_res = {{(ALU_W-1){1'b0}}, $signed(i_req.op1) < $signed(i_req.op2)};
      ALU_SLTU: w_res = {{(ALU_W-1){1'b0}}, i_req.op1 < i_req.op2};
      ALU_XOR:  w_res = i_req.op1 ^ i_req.op2;
      ALU_SRL:  w_res = i_req.op1 >> w_shamt;
      ALU_SRA:  w_res = $unsigned($signed(i_req.op1) >>> w_shamt);
      ALU_OR:   w_res = i_req.op1 | i_req.op2;
      ALU_AND:  w_res = i_req.op1 & i_req.op2;
      default:  w_res = '0;
    endcase
  end

  assign o_rsp.result = w_res;
  assign o_rsp.zero   = (w_res == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port share arbiter around one ALU with a registered response slot per
// port. Optional perf counters are enabled by defining ALU_ARB_PERF_EN.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [3:0]        req0_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_zero,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [3:0]        req1_op,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_zero
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_conflict
`endif
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("alu_share_arbiter: DATA_W must be 32");
  end

  logic [1:0]       w_req_valid, w_resp_ready, w_elig, w_grant;
  alu_req_t         w_req [2];
  alu_req_t         w_alu_req;
  alu_rsp_t         w_alu_rsp;
  slot_e            r_slot [2];
  slot_e            w_slot_nxt [2];
  logic [ALU_W-1:0] r_result [2];
  logic [1:0]       r_zero;
  logic             r_last_grant;

  assign w_req_valid  = {req1_valid, req0_valid};
  assign w_resp_ready = {resp1_ready, resp0_ready};
  assign w_req[0]     = '{op1: req0_op1, op2: req0_op2, op: req0_op};
  assign w_req[1]     = '{op1: req1_op1, op2: req1_op2, op: req1_op};

  // A full slot being drained this cycle may be refilled in the same cycle.
  always_comb begin
    for (int i = 0; i < 2; i++)
      w_elig[i] = w_req_valid[i] && (r_slot[i] == SLOT_EMPTY || w_resp_ready[i]);
  end

  always_comb begin
    w_grant = '0;
    if (rst_n) begin
      if (&w_elig) begin
        if (FIXED_PRIO != 0 || r_last_grant == ARB_PORT1) w_grant[0] = 1'b1;
        else                                             w_grant[1] = 1'b1;
      end else begin
        w_grant = w_elig;
      end
    end
  end

  assign w_alu_req = w_grant[1] ? w_req[1] : w_req[0];

  alu_share_arbiter_alu u_alu (
    .i_req (w_alu_req),
    .o_rsp (w_alu_rsp)
  );

  // Slot FSM next state: grant wins over drain.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_slot_nxt[i] = r_slot[i];
      if (w_grant[i])           w_slot_nxt[i] = SLOT_FULL;
      else if (w_resp_ready[i]) w_slot_nxt[i] = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_slot[i]   <= SLOT_EMPTY;
        r_result[i] <= '0;
      end
      r_zero       <= '0;
      r_last_grant <= ARB_PORT1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_slot[i] <= w_slot_nxt[i];
        if (w_grant[i]) begin
          r_result[i] <= w_alu_rsp.result;
          r_zero[i]   <= w_alu_rsp.zero;
        end
      end
      if (w_grant[1])      r_last_grant <= ARB_PORT1;
      else if (w_grant[0]) r_last_grant <= ARB_PORT0;
    end
  end

  assign req0_ready   = w_grant[0];
  assign req1_ready   = w_grant[1];
  assign resp0_valid  = (r_slot[0] == SLOT_FULL);
  assign resp1_valid  = (r_slot[1] == SLOT_FULL);
  assign resp0_result = r_result[0];
  assign resp1_result = r_result[1];
  assign resp0_zero   = r_zero[0];
  assign resp1_zero   = r_zero[1];

`ifdef ALU_ARB_PERF_EN
  logic [31:0] r_perf_grant [2];
  logic [31:0] r_perf_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_grant[0] <= '0;
      r_perf_grant[1] <= '0;
      r_perf_conflict <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (w_grant[i] && r_perf_grant[i] != '1) r_perf_grant[i] <= r_perf_grant[i] + 32'd1;
      if ((&w_elig) && r_perf_conflict != '1) r_perf_conflict <= r_perf_conflict + 32'd1;
    end
  end

  assign perf_grant0   = r_perf_grant[0];
  assign perf_grant1   = r_perf_grant[1];
  assign perf_conflict = r_perf_conflict;
`endif

endmodule
